md_ctrl: RTL
============

Name: md_ctrl

Overview:
Multi-cycle multiply/divide controller in the EX stage, beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and owns the HI/LO registers. It sequences each operation through a fixed-latency busy window and produces the stall request the hazard unit needs. A start that coincides with an exception or interrupt cancel is suppressed, so HI/LO are never committed by a squashed instruction.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  EX-stage instruction is an MD op this cycle
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
rs_data  input  32  operand A, forwarded rs value
rt_data  input  32  operand B, forwarded rt value
cancel  input  1  exception/interrupt flush this cycle; suppresses start
md_inst_d  input  1  ID-stage instruction uses HI/LO (MD op, MFHI, MFLO)
busy  output  1  operation in progress
stall  output  1  stall request to the hazard unit
hi  output  32  HI register, read by MFHI
lo  output  32  LO register, read by MFLO

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE, counter 0, busy=0
  - hi=0, lo=0
  - all pending-result registers 0
  - takes effect immediately, including mid-RUN; the in-flight operation is discarded.
- go = start & ~cancel & ~busy.
- go with op=reserved (6, 7): no effect.
- States: IDLE, RUN.
- IDLE, go with op 0-3:
  - latch result into pend_hi/pend_lo
  - load counter with MULT_CYCLES (op 0, 1) or DIV_CYCLES (op 2, 3)
  - enter RUN at the same edge.
- IDLE, go with op 4 (MTHI): hi<=rs_data at that edge. op 5 (MTLO): lo<=rs_data at that edge. No busy, stay IDLE.
- RUN:
  - counter decrements every edge
  - at the edge where counter==1: hi<=pend_hi, lo<=pend_lo, counter<=0, return to IDLE.
- busy=(state==RUN), registered. For an op started at edge T, busy is 1 for exactly N cycles after T. New hi/lo are visible in the first cycle with busy=0.
- start while busy=1 is ignored; the hazard unit is responsible for never issuing it. cancel has no effect on a RUN already in progress, because its instruction has already committed past EX.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64 product.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64 product.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned lo = quotient, hi = remainder.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (rt_data=0, DIV or DIVU): full DIV_CYCLES busy window; at completion hi/lo keep their pre-op values. pend_* is loaded from current hi/lo.
  - No overflow exceptions are raised by this block.
- stall = md_inst_d & (busy | (start & ~cancel & op<=3)). Combinational. Holds ID while an MD op runs or is being issued, so MFHI/MFLO never read stale values.
- hi/lo are outputs of registers only (no bypass of pend_*).

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=2, start one cycle -> busy high exactly 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE. hi/lo unchanged during busy.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands -> lo=0x7FFFFFFC, hi=1.
- MTHI rs=0x12345678 with hi=lo=0, then DIV rt=0 -> hi=0x12345678 next cycle, busy 0. Busy then 10 cycles; afterwards hi=0x12345678, lo=0.
- start (MULT 3x4) with cancel=1 in the same cycle -> busy stays 0, stall=0, hi/lo unchanged. Same op with cancel asserted during RUN -> completes normally, lo=12.
- md_inst_d=1 during RUN and in the start cycle -> stall=1 in each of those cycles. md_inst_d=0 -> stall=0. start with op=MULT while busy -> ignored; result is that of the first op only.
- Assert reset low mid-RUN (counter=3) asynchronously, between clock edges -> busy, hi, lo go to 0 immediately. After release, a fresh MULT 0xFFFFFFFF x 0xFFFFFFFF yields hi=0, lo=1 after 5 busy cycles.

Source files
------------

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide controller beside the EX-stage ALU.
// Owns HI/LO. Each MULT/DIV computes its result at issue, parks it in the
// pending registers, and commits it to HI/LO after a fixed busy window.
// A start that coincides with a cancel never touches HI/LO.

module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        cancel,
   input  logic        md_inst_d,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      state_r, state_nxt_s;
   logic [3:0]  cnt_r, cnt_nxt_s;
   logic        busy_r;
   logic [31:0] hi_r, hi_nxt_s;
   logic [31:0] lo_r, lo_nxt_s;
   logic [31:0] pend_hi_r, pend_hi_nxt_s;
   logic [31:0] pend_lo_r, pend_lo_nxt_s;

   logic        go_s;
   logic        md_op_s;
   logic [63:0] res_s;

   // Two's-complement negate, used for magnitude and sign restoration.
   function automatic logic [31:0] neg32(input logic [31:0] v);
      return 32'd0 - v;
   endfunction

   // Arithmetic datapath
   logic signed [63:0] a_sx_s, b_sx_s;
   logic [63:0]        prod_s_s, prod_u_s;
   logic               div_sgn_s, q_neg_s, r_neg_s;
   logic [31:0]        div_a_s, div_b_s, uq_s, ur_s, quo_s, rem_s;

   assign a_sx_s   = {{32{rs_data[31]}}, rs_data};
   assign b_sx_s   = {{32{rt_data[31]}}, rt_data};
   assign prod_s_s = a_sx_s * b_sx_s;
   assign prod_u_s = {32'd0, rs_data} * {32'd0, rt_data};

   // Signed divide runs on magnitudes through the same unsigned divider;
   // the most-negative / -1 case falls out naturally as 0x80000000 rem 0.
   assign div_sgn_s = (op == OP_DIV);
   assign q_neg_s   = div_sgn_s & (rs_data[31] ^ rt_data[31]);
   assign r_neg_s   = div_sgn_s & rs_data[31];
   assign div_a_s   = (div_sgn_s & rs_data[31]) ? neg32(rs_data) : rs_data;
   assign div_b_s   = (div_sgn_s & rt_data[31]) ? neg32(rt_data) : rt_data;
   assign uq_s      = (div_b_s == 32'd0) ? 32'd0 : (div_a_s / div_b_s);
   assign ur_s      = (div_b_s == 32'd0) ? 32'd0 : (div_a_s % div_b_s);
   assign quo_s     = q_neg_s ? neg32(uq_s) : uq_s;
   assign rem_s     = r_neg_s ? neg32(ur_s) : ur_s;

   // Select the {hi,lo} result for the op presented this cycle.
   always_comb begin
      res_s = {hi_r, lo_r};
      case (op)
         OP_MULT:  res_s = prod_s_s;
         OP_MULTU: res_s = prod_u_s;
         OP_DIV, OP_DIVU: begin
            if (rt_data == 32'd0) begin
               res_s = {hi_r, lo_r};
            end else begin
               res_s = {rem_s, quo_s};
            end
         end
         default:  res_s = {hi_r, lo_r};
      endcase
   end

   assign go_s    = start & ~cancel & ~busy_r;
   assign md_op_s = (op <= OP_DIVU);

   // Next-state, counter and HI/LO/pending update logic.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      hi_nxt_s      = hi_r;
      lo_nxt_s      = lo_r;
      pend_hi_nxt_s = pend_hi_r;
      pend_lo_nxt_s = pend_lo_r;
      case (state_r)
         ST_IDLE: begin
            if (go_s) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     pend_hi_nxt_s = res_s[63:32];
                     pend_lo_nxt_s = res_s[31:0];
                     cnt_nxt_s     = MULT_LD;
                     state_nxt_s   = ST_RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_nxt_s = res_s[63:32];
                     pend_lo_nxt_s = res_s[31:0];
                     cnt_nxt_s     = DIV_LD;
                     state_nxt_s   = ST_RUN;
                  end
                  OP_MTHI: hi_nxt_s = rs_data;
                  OP_MTLO: lo_nxt_s = rs_data;
                  default: state_nxt_s = ST_IDLE;
               endcase
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == 4'd1) begin
               hi_nxt_s    = pend_hi_r;
               lo_nxt_s    = pend_lo_r;
               cnt_nxt_s   = 4'd0;
               state_nxt_s = ST_IDLE;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // State, counter and result registers; reset discards any in-flight op.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 4'd0;
         busy_r    <= 1'b0;
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
         pend_hi_r <= 32'd0;
         pend_lo_r <= 32'd0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         busy_r    <= (state_nxt_s == ST_RUN);
         hi_r      <= hi_nxt_s;
         lo_r      <= lo_nxt_s;
         pend_hi_r <= pend_hi_nxt_s;
         pend_lo_r <= pend_lo_nxt_s;
      end
   end

   assign busy  = busy_r;
   assign hi    = hi_r;
   assign lo    = lo_r;
   // Hold ID while an MD op runs or is being issued so MFHI/MFLO never read stale values.
   assign stall = md_inst_d & (busy_r | (start & ~cancel & md_op_s));

endmodule
